// File: rtl/dec_frame_ctrl.sv
// dec_frame_ctrl
// Sequencing and frame-acceptance controller for the serial remote-control
// decoder. It provides the bit-period and sync-period timebases the decoder
// uses. It also confirms decoded frames before publishing them, drops the
// published value when the link goes quiet, and keeps a saturating count of
// decode errors.
module dec_frame_ctrl #(
    parameter int unsigned BIT_LEN  = 32,
    parameter int unsigned SYNC_LEN = 128,
    parameter int unsigned CONFIRM  = 2,
    parameter int unsigned TIMEOUT  = 24000
) (
    input  logic       clk_12kHz,
    input  logic       rst,
    input  logic       dec_start_count,
    input  logic       dec_start_sync,
    input  logic       dv,
    input  logic [3:0] dado_in,
    input  logic       error_flag,
    input  logic       err_clr,
    output logic [4:0] dec_count,
    output logic       dec_fim_count,
    output logic [6:0] dec_count_sync,
    output logic       dec_fim_sync,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       new_data,
    output logic       link_lost,
    output logic [7:0] err_count
);

    // Frame FSM encodings, kept as plain constants so the state register
    // stays a simple two-bit vector in the legacy netlist.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CAND   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [4:0]  BIT_LAST     = 5'(BIT_LEN - 1);
    localparam logic [6:0]  SYNC_LAST    = 7'(SYNC_LEN - 1);
    localparam logic [14:0] TIMEOUT_LAST = 15'(TIMEOUT - 1);
    localparam logic [2:0]  CONFIRM_M    = 3'(CONFIRM);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [4:0]  bit_cnt_q,   bit_cnt_d;
    logic [6:0]  sync_cnt_q,  sync_cnt_d;
    logic        dv_q;
    logic [14:0] timer_q,     timer_d;
    logic [1:0]  state_q,     state_d;
    logic [3:0]  cand_q,      cand_d;
    logic [2:0]  match_q,     match_d;
    logic [3:0]  data_out_q,  data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        new_data_q,  new_data_d;
    logic        link_lost_q, link_lost_d;
    logic [7:0]  err_cnt_q,   err_cnt_d;

    logic        dv_rise;
    logic        timeout;
    logic [2:0]  match_inc;

    assign dv_rise   = dv && !dv_q;
    assign timeout   = (state_q != ST_IDLE) && (timer_q == TIMEOUT_LAST);
    assign match_inc = match_q + 3'd1;

    // Bit-period counter: runs while enabled, wraps at BIT_LEN-1, clears when idle
    always_comb begin
        bit_cnt_d = '0;
        if (dec_start_count) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 5'd1;
        end
    end

    // Sync-period counter: same rules as the bit counter, independent enable
    always_comb begin
        sync_cnt_d = '0;
        if (dec_start_sync) begin
            sync_cnt_d = (sync_cnt_q == SYNC_LAST) ? '0 : sync_cnt_q + 7'd1;
        end
    end

    // Frame acceptance FSM: confirm, publish, withdraw and time out frames
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        match_d      = match_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        new_data_d   = 1'b0;
        link_lost_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dv_rise) begin
                    cand_d  = dado_in;
                    match_d = 3'd1;
                    if (CONFIRM == 1) begin
                        state_d      = ST_LOCKED;
                        data_out_d   = dado_in;
                        data_valid_d = 1'b1;
                        new_data_d   = 1'b1;
                    end else begin
                        state_d = ST_CAND;
                    end
                end
            end

            ST_CAND: begin
                if (dv_rise) begin
                    if (dado_in == cand_q) begin
                        match_d = match_inc;
                        if (match_inc == CONFIRM_M) begin
                            state_d      = ST_LOCKED;
                            data_out_d   = dado_in;
                            data_valid_d = 1'b1;
                            new_data_d   = 1'b1;
                        end
                    end else begin
                        cand_d  = dado_in;
                        match_d = 3'd1;
                    end
                end else if (error_flag || timeout) begin
                    state_d = ST_IDLE;
                    cand_d  = '0;
                    match_d = '0;
                end
            end

            ST_LOCKED: begin
                if (dv_rise) begin
                    if (dado_in != data_out_q) begin
                        cand_d       = dado_in;
                        match_d      = 3'd1;
                        // With single-frame confirmation a new value is
                        // already confirmed, so it republishes in place.
                        if (CONFIRM == 1) begin
                            data_out_d   = dado_in;
                            data_valid_d = 1'b1;
                            new_data_d   = 1'b1;
                        end else begin
                            state_d      = ST_CAND;
                            data_valid_d = 1'b0;
                        end
                    end
                end else if (timeout) begin
                    state_d      = ST_IDLE;
                    data_valid_d = 1'b0;
                    link_lost_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gap timer: restarts on every frame edge, idles at zero outside CAND/LOCKED
    always_comb begin
        timer_d = timer_q + 15'd1;
        if (dv_rise || (state_d == ST_IDLE)) begin
            timer_d = '0;
        end
    end

    // Error counter: clear wins, otherwise count each flagged cycle up to 255
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (error_flag && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State update with synchronous active-high reset
    always_ff @(posedge clk_12kHz) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            sync_cnt_q   <= '0;
            dv_q         <= 1'b0;
            timer_q      <= '0;
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            match_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            new_data_q   <= 1'b0;
            link_lost_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            sync_cnt_q   <= sync_cnt_d;
            dv_q         <= dv;
            timer_q      <= timer_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            new_data_q   <= new_data_d;
            link_lost_q  <= link_lost_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dec_count      = bit_cnt_q;
    assign dec_fim_count  = (bit_cnt_q == BIT_LAST) && dec_start_count;
    assign dec_count_sync = sync_cnt_q;
    assign dec_fim_sync   = (sync_cnt_q == SYNC_LAST) && dec_start_sync;
    assign data_out       = data_out_q;
    assign data_valid     = data_valid_q;
    assign new_data       = new_data_q;
    assign link_lost      = link_lost_q;
    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_dec_frame_ctrl.sv
// Testbench for dec_frame_ctrl: directed stimulus with hand-computed
// expectations. Publication and link-loss events go through a scoreboard
// queue that an independent negedge monitor drains.
module tb_dec_frame_ctrl;

    logic       clk_12kHz;
    logic       rst;
    logic       dec_start_count;
    logic       dec_start_sync;
    logic       dv;
    logic [3:0] dado_in;
    logic       error_flag;
    logic       err_clr;
    logic [4:0] dec_count;
    logic       dec_fim_count;
    logic [6:0] dec_count_sync;
    logic       dec_fim_sync;
    logic [3:0] data_out;
    logic       data_valid;
    logic       new_data;
    logic       link_lost;
    logic [7:0] err_count;

    dec_frame_ctrl #(
        .BIT_LEN (32),
        .SYNC_LEN(128),
        .CONFIRM (2),
        .TIMEOUT (24000)
    ) dut (
        .clk_12kHz      (clk_12kHz),
        .rst            (rst),
        .dec_start_count(dec_start_count),
        .dec_start_sync (dec_start_sync),
        .dv             (dv),
        .dado_in        (dado_in),
        .error_flag     (error_flag),
        .err_clr        (err_clr),
        .dec_count      (dec_count),
        .dec_fim_count  (dec_fim_count),
        .dec_count_sync (dec_count_sync),
        .dec_fim_sync   (dec_fim_sync),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .new_data       (new_data),
        .link_lost      (link_lost),
        .err_count      (err_count)
    );

    initial clk_12kHz = 1'b0;
    always #5 clk_12kHz = ~clk_12kHz;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         ll;   // 1: link_lost event, 0: new_data event
        logic [3:0] d;    // data_out expected while the event is shown
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_12kHz);
        #1;
    endtask

    task automatic frame(input logic [3:0] d);
        dv      = 1'b1;
        dado_in = d;
        tick(1);
        dv      = 1'b0;
        tick(1);
    endtask

    task automatic push_ev(input bit ll, input logic [3:0] d);
        ev_t e;
        e.ll = ll;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every new_data / link_lost pulse must match the next expected event
    always @(negedge clk_12kHz) begin
        if (new_data === 1'b1 || link_lost === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event new_data=%0b link_lost=%0b data_out=%0h expected no event",
                         new_data, link_lost, data_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_link_lost", {31'd0, link_lost}, {31'd0, mon_e.ll});
                chk("ev_new_data", {31'd0, new_data}, {31'd0, !mon_e.ll});
                chk("ev_data_out", {28'd0, data_out}, {28'd0, mon_e.d});
                chk("ev_data_valid", {31'd0, data_valid}, {31'd0, !mon_e.ll});
            end
        end
    end

    initial begin
        rst             = 1'b1;
        dec_start_count = 1'b0;
        dec_start_sync  = 1'b0;
        dv              = 1'b0;
        dado_in         = 4'h0;
        error_flag      = 1'b0;
        err_clr         = 1'b0;
        tick(1);

        // Reset state
        chk("rst_dec_count", dec_count, 0);
        chk("rst_fim_count", dec_fim_count, 0);
        chk("rst_count_sync", dec_count_sync, 0);
        chk("rst_fim_sync", dec_fim_sync, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_new_data", new_data, 0);
        chk("rst_link_lost", link_lost, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        tick(1);

        // Bit counter: 40 enabled cycles, wrap at 31, fim only at 31
        dec_start_count = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("bit_count", dec_count, i % 32);
            chk("bit_fim", dec_fim_count, (i % 32 == 31) ? 1 : 0);
            tick(1);
        end
        chk("bit_count_40", dec_count, 8);
        dec_start_count = 1'b0;
        chk("bit_fim_disabled", dec_fim_count, 0);
        tick(1);
        chk("bit_count_cleared", dec_count, 0);

        // Sync counter: 130 enabled cycles, wrap at 127
        dec_start_sync = 1'b1;
        for (int i = 0; i < 130; i++) begin
            chk("sync_count", dec_count_sync, i % 128);
            chk("sync_fim", dec_fim_sync, (i % 128 == 127) ? 1 : 0);
            tick(1);
        end
        dec_start_sync = 1'b0;
        tick(1);
        chk("sync_count_cleared", dec_count_sync, 0);

        // Both counters together advance independently
        dec_start_count = 1'b1;
        dec_start_sync  = 1'b1;
        tick(3);
        chk("both_bit", dec_count, 3);
        chk("both_sync", dec_count_sync, 3);
        dec_start_count = 1'b0;
        dec_start_sync  = 1'b0;
        tick(1);

        // Confirmation: two A frames 4000 cycles apart
        dv = 1'b1; dado_in = 4'hA;
        tick(1);
        dv = 1'b0;
        chk("single_frame_valid", data_valid, 0);
        tick(3999);
        chk("single_frame_valid_late", data_valid, 0);
        push_ev(1'b0, 4'hA);
        dv = 1'b1;
        tick(1);
        dv = 1'b0;
        chk("confirm_data_out", data_out, 4'hA);
        chk("confirm_data_valid", data_valid, 1);
        chk("confirm_new_data", new_data, 1);
        tick(1);
        chk("confirm_new_data_one_cycle", new_data, 0);

        // Mismatch sequence A,5,5 from a clean start
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        frame(4'hA);
        chk("mm_after_A", data_valid, 0);
        frame(4'h5);
        chk("mm_after_5a", data_valid, 0);
        push_ev(1'b0, 4'h5);
        frame(4'h5);
        chk("mm_locked_valid", data_valid, 1);
        chk("mm_locked_data", data_out, 4'h5);
        frame(4'h3);
        chk("mm_withdraw_valid", data_valid, 0);
        chk("mm_withdraw_data", data_out, 4'h5);
        push_ev(1'b0, 4'h3);
        frame(4'h3);
        chk("mm_relock_valid", data_valid, 1);
        chk("mm_relock_data", data_out, 4'h3);

        // error_flag in LOCKED keeps the lock
        error_flag = 1'b1;
        tick(1);
        error_flag = 1'b0;
        chk("err_locked_valid", data_valid, 1);
        chk("err_locked_count", err_count, 1);
        frame(4'h3);
        chk("err_locked_same_frame", data_valid, 1);

        // error_flag in CAND drops back to IDLE
        frame(4'h7);
        chk("cand7_valid", data_valid, 0);
        error_flag = 1'b1;
        tick(1);
        error_flag = 1'b0;
        frame(4'h7);
        chk("err_cand_discard", data_valid, 0);
        push_ev(1'b0, 4'h7);
        frame(4'h7);
        chk("cand_relock_valid", data_valid, 1);
        chk("err_count_2", err_count, 2);

        // Timeout: link_lost exactly 24000 edges after the locking frame
        tick(23998);
        chk("to_before_valid", data_valid, 1);
        chk("to_before_link_lost", link_lost, 0);
        push_ev(1'b1, 4'h7);
        tick(1);
        chk("to_valid_dropped", data_valid, 0);
        chk("to_link_lost", link_lost, 1);
        chk("to_data_retained", data_out, 4'h7);
        tick(1);
        chk("to_link_lost_one_cycle", link_lost, 0);

        // Frame on the timeout cycle wins over the timeout
        frame(4'h7);
        push_ev(1'b0, 4'h7);
        frame(4'h7);
        tick(23998);
        dv = 1'b1; dado_in = 4'h7;
        tick(1);
        dv = 1'b0;
        chk("to_race_valid", data_valid, 1);
        chk("to_race_link_lost", link_lost, 0);
        tick(5);
        chk("to_race_valid_late", data_valid, 1);

        // err_count saturation and clear priority
        error_flag = 1'b1;
        tick(300);
        chk("err_saturate", err_count, 255);
        err_clr = 1'b1;
        tick(1);
        chk("err_clr_priority", err_count, 0);
        err_clr = 1'b0;
        tick(1);
        error_flag = 1'b0;
        chk("err_after_clr", err_count, 1);
        chk("err_long_locked", data_valid, 1);

        // Reset mid-operation
        dec_start_count = 1'b1;
        dec_start_sync  = 1'b1;
        tick(5);
        chk("mid_bit", dec_count, 5);
        chk("mid_sync", dec_count_sync, 5);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("async_rst_bit", dec_count, 5);
        chk("async_rst_valid", data_valid, 1);
        chk("async_rst_err", err_count, 1);
        tick(1);
        chk("async_rst_bit_next", dec_count, 6);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_bit", dec_count, 0);
        chk("mid_rst_fim", dec_fim_count, 0);
        chk("mid_rst_sync", dec_count_sync, 0);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_new_data", new_data, 0);
        chk("mid_rst_link_lost", link_lost, 0);
        chk("mid_rst_err", err_count, 0);
        rst = 1'b0;
        dec_start_count = 1'b0;
        dec_start_sync  = 1'b0;
        frame(4'h7);
        chk("post_rst_idle", data_valid, 0);
        tick(5);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
